slurm32_cpu_load_store_unit: RTL and testbench

Execute-stage load/store unit for the SLURM32 pipeline. It accepts one pre-decoded memory operation per handshake and computes the effective address. It generates lane masks and replicated store data, runs a ready/ack transaction to the memory port, and returns extracted, sign- or zero-extended load data to writeback. It stalls the pipeline while a transaction is outstanding and reports misaligned accesses instead of issuing them.

---
 rtl/slurm32_cpu_load_store_unit_if.sv | 53 +++++
 rtl/slurm32_cpu_load_store_unit.sv | 188 ++++++++++++++++++
 tb/tb_slurm32_cpu_load_store_unit.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slurm32_cpu_load_store_unit_if.sv
// Bundle between the SLURM32 execute stage, the load/store unit, its memory port and writeback.
// Request handshake: an op transfers on a rising clock edge where req_valid && req_ready (and no flush).
// Memory handshake: mem_req stays high with stable fields until the cycle mem_ack is sampled high.
interface slurm32_cpu_load_store_unit_if #(
    parameter int BITS          = 32,
    parameter int ADDRESS_BITS  = 32,
    parameter int REGISTER_BITS = 4
);
    localparam int NL = BITS / 8;
    localparam int LB = $clog2(NL);

    logic                         req_valid;
    logic                         req_ready;
    logic                         req_load;
    logic [1:0]                   req_size;
    logic                         req_signed;
    logic [BITS-1:0]              req_base;
    logic [23:0]                  req_offset;
    logic [BITS-1:0]              req_store_data;
    logic [REGISTER_BITS-1:0]     req_dest;
    logic                         flush;

    logic                         mem_req;
    logic                         mem_we;
    logic [ADDRESS_BITS-LB-1:0]   mem_addr;
    logic [BITS-1:0]              mem_wdata;
    logic [NL-1:0]                mem_mask;
    logic                         mem_ack;
    logic [BITS-1:0]              mem_rdata;

    logic                         wb_valid;
    logic [REGISTER_BITS-1:0]     wb_reg;
    logic [BITS-1:0]              wb_data;
    logic                         stall;
    logic                         misalign;

    // Debug view of the unit's FSM state (0=IDLE, 1=ACCESS, 2=WB).
    logic [1:0]                   dbg_state;

    modport master (
        output req_valid, req_load, req_size, req_signed, req_base, req_offset,
               req_store_data, req_dest, flush, mem_ack, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
               wb_valid, wb_reg, wb_data, stall, misalign, dbg_state
    );

    modport slave (
        input  req_valid, req_load, req_size, req_signed, req_base, req_offset,
               req_store_data, req_dest, flush, mem_ack, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
               wb_valid, wb_reg, wb_data, stall, misalign, dbg_state
    );
endinterface

// File: rtl/slurm32_cpu_load_store_unit.sv
// SLURM32 execute-stage load/store unit: effective address, lane mask, store replication,
// single outstanding memory transaction, and extended load data returned to writeback.
module slurm32_cpu_load_store_unit #(
    parameter int BITS          = 32,
    parameter int ADDRESS_BITS  = 32,
    parameter int REGISTER_BITS = 4
) (
    input logic                          CLK,
    input logic                          RSTb,
    slurm32_cpu_load_store_unit_if.slave bus
);
    localparam int NL = BITS / 8;
    localparam int LB = $clog2(NL);
    localparam int AW = ADDRESS_BITS - LB;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WB     = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            addr_q, addr_d;
    logic                     we_q, we_d;
    logic [BITS-1:0]          wdata_q, wdata_d;
    logic [NL-1:0]            mask_q, mask_d;
    logic [REGISTER_BITS-1:0] dest_q, dest_d;
    logic [1:0]               size_q, size_d;
    logic                     signed_q, signed_d;
    logic [LB-1:0]            lane_q, lane_d;
    logic                     killed_q, killed_d;
    logic                     misalign_q, misalign_d;
    logic [REGISTER_BITS-1:0] wb_reg_q, wb_reg_d;
    logic [BITS-1:0]          wb_data_q, wb_data_d;

    logic [ADDRESS_BITS-1:0]  offset_ext;
    logic [ADDRESS_BITS-1:0]  ea;
    logic [LB-1:0]            lane;
    logic                     size_ok;
    logic [NL-1:0]            mask_base;
    logic [NL-1:0]            mask;
    logic [BITS-1:0]          wdata_rep;
    logic [BITS-1:0]          rd_shift;
    logic [BITS-1:0]          load_ext;

    // Request-side datapath: address, alignment, lane mask and replicated store data.
    always_comb begin
        offset_ext = {{(ADDRESS_BITS-24){bus.req_offset[23]}}, bus.req_offset};
        ea         = ADDRESS_BITS'(bus.req_base) + offset_ext;
        lane       = ea[LB-1:0];

        case (bus.req_size)
            2'd0:    size_ok = 1'b1;
            2'd1:    size_ok = ~ea[0];
            2'd2:    size_ok = (ea[1:0] == 2'b00);
            default: size_ok = (BITS == 64) && (ea[2:0] == 3'b000);
        endcase

        case (bus.req_size)
            2'd0:    mask_base = NL'(1);
            2'd1:    mask_base = NL'(3);
            2'd2:    mask_base = NL'(15);
            default: mask_base = {NL{1'b1}};
        endcase
        mask = mask_base << lane;

        case (bus.req_size)
            2'd0:    wdata_rep = {NL{bus.req_store_data[7:0]}};
            2'd1:    wdata_rep = {(NL/2){bus.req_store_data[15:0]}};
            2'd2:    wdata_rep = {(NL/4){bus.req_store_data[31:0]}};
            default: wdata_rep = bus.req_store_data;
        endcase
    end

    // Response-side datapath: pick the addressed bytes out of the returned word and extend.
    always_comb begin
        rd_shift = bus.mem_rdata >> {lane_q, 3'b000};
        case (size_q)
            2'd0:    load_ext = signed_q ? BITS'($signed(rd_shift[7:0]))  : BITS'(rd_shift[7:0]);
            2'd1:    load_ext = signed_q ? BITS'($signed(rd_shift[15:0])) : BITS'(rd_shift[15:0]);
            2'd2:    load_ext = signed_q ? BITS'($signed(rd_shift[31:0])) : BITS'(rd_shift[31:0]);
            default: load_ext = rd_shift;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        mask_d     = mask_q;
        dest_d     = dest_q;
        size_d     = size_q;
        signed_d   = signed_q;
        lane_d     = lane_q;
        killed_d   = killed_q;
        misalign_d = 1'b0;
        wb_reg_d   = wb_reg_q;
        wb_data_d  = wb_data_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && !bus.flush) begin
                    if (!size_ok) begin
                        misalign_d = 1'b1;
                    end else begin
                        addr_d   = ea[ADDRESS_BITS-1:LB];
                        we_d     = ~bus.req_load;
                        wdata_d  = wdata_rep;
                        mask_d   = mask;
                        dest_d   = bus.req_dest;
                        size_d   = bus.req_size;
                        signed_d = bus.req_signed;
                        lane_d   = lane;
                        killed_d = 1'b0;
                        state_d  = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // Memory cannot abort, so a flushed load still waits for its ack but is dropped.
                if (bus.flush && !we_q) begin
                    killed_d = 1'b1;
                end
                if (bus.mem_ack) begin
                    if (we_q || killed_q || bus.flush) begin
                        state_d = IDLE;
                    end else begin
                        wb_reg_d  = dest_q;
                        wb_data_d = load_ext;
                        state_d   = WB;
                    end
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            mask_q     <= '0;
            dest_q     <= '0;
            size_q     <= 2'd0;
            signed_q   <= 1'b0;
            lane_q     <= '0;
            killed_q   <= 1'b0;
            misalign_q <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            mask_q     <= mask_d;
            dest_q     <= dest_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            lane_q     <= lane_d;
            killed_q   <= killed_d;
            misalign_q <= misalign_d;
            wb_reg_q   <= wb_reg_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.stall     = (state_q != IDLE);
    assign bus.mem_req   = (state_q == ACCESS);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_mask  = mask_q;
    assign bus.wb_valid  = (state_q == WB);
    assign bus.wb_reg    = wb_reg_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.misalign  = misalign_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_slurm32_cpu_load_store_unit.sv
// Directed bench for the SLURM32 load/store unit: a cycle-level expectation model plus
// hand-computed literal checks, with a 64-bit instance for the dword path.
module tb_slurm32_cpu_load_store_unit;
    logic CLK = 1'b0;
    logic RSTb;
    always #5 CLK = ~CLK;

    slurm32_cpu_load_store_unit_if #(.BITS(32), .ADDRESS_BITS(32), .REGISTER_BITS(4)) bus ();
    slurm32_cpu_load_store_unit_if #(.BITS(64), .ADDRESS_BITS(32), .REGISTER_BITS(4)) bus64 ();

    slurm32_cpu_load_store_unit #(.BITS(32), .ADDRESS_BITS(32), .REGISTER_BITS(4)) dut (
        .CLK  (CLK),
        .RSTb (RSTb),
        .bus  (bus.slave)
    );

    slurm32_cpu_load_store_unit #(.BITS(64), .ADDRESS_BITS(32), .REGISTER_BITS(4)) dut64 (
        .CLK  (CLK),
        .RSTb (RSTb),
        .bus  (bus64.slave)
    );

    int errors = 0;
    int checks = 0;

    // Expected outputs, updated by the driver from the latency rules.
    logic        exp_busy     = 1'b0;
    logic        exp_mem_req  = 1'b0;
    logic        exp_wb_valid = 1'b0;
    logic        exp_misalign = 1'b0;
    logic        exp_we       = 1'b0;
    logic [29:0] exp_addr     = '0;
    logic [3:0]  exp_mask     = '0;
    logic [31:0] exp_wdata    = '0;
    logic [35:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the specification rules.
    function automatic logic [31:0] m_ea(input logic [31:0] base, input logic [23:0] off);
        return base + {{8{off[23]}}, off};
    endfunction

    function automatic bit m_legal(input logic [1:0] size, input logic [31:0] ea);
        int n;
        n = 1 << size;
        if (size == 2'd3) return 1'b0;
        return (ea % n) == 0;
    endfunction

    function automatic logic [3:0] m_mask(input logic [1:0] size, input logic [31:0] ea);
        int n;
        int v;
        n = 1 << size;
        v = ((1 << n) - 1) << (ea % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] sdata);
        logic [31:0] r;
        int n;
        n = 1 << size;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sdata[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input bit sgn,
                                           input logic [31:0] ea, input logic [31:0] rdata);
        longint unsigned v;
        int nb;
        nb = 8 * (1 << size);
        v = 64'(rdata) >> (8 * (ea % 4));
        v = v & ((64'd1 << nb) - 1);
        if (sgn && v[nb-1]) v = v - (64'd1 << nb);
        return v[31:0];
    endfunction

    // Cycle compare against the expectation model.
    always @(negedge CLK) begin
        logic [35:0] e;
        check("req_ready", bus.req_ready, !exp_busy);
        check("stall", bus.stall, exp_busy);
        check("mem_req", bus.mem_req, exp_mem_req);
        check("wb_valid", bus.wb_valid, exp_wb_valid);
        check("misalign", bus.misalign, exp_misalign);
        if (exp_mem_req) begin
            check("mem_we", bus.mem_we, exp_we);
            check("mem_addr", bus.mem_addr, exp_addr);
            check("mem_mask", bus.mem_mask, exp_mask);
            check("mem_wdata", bus.mem_wdata, exp_wdata);
        end
        if (bus.wb_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got wb_valid=1 expected no result at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("wb_reg", bus.wb_reg, e[35:32]);
                check("wb_data", bus.wb_data, e[31:0]);
            end
        end
    end

    task automatic do_op(input bit load, input logic [1:0] size, input bit sgn,
                         input logic [31:0] base, input logic [23:0] off,
                         input logic [31:0] sdata, input logic [3:0] dest,
                         input int wait_cyc, input logic [31:0] rdata, input int flush_cyc);
        logic [31:0] ea;
        bit killed;
        ea = m_ea(base, off);
        killed = 1'b0;
        bus.req_valid      = 1'b1;
        bus.req_load       = load;
        bus.req_size       = size;
        bus.req_signed     = sgn;
        bus.req_base       = base;
        bus.req_offset     = off;
        bus.req_store_data = sdata;
        bus.req_dest       = dest;
        @(posedge CLK); #1;
        bus.req_valid = 1'b0;
        if (!m_legal(size, ea)) begin
            exp_misalign = 1'b1;
            @(posedge CLK); #1;
            exp_misalign = 1'b0;
            return;
        end
        exp_busy    = 1'b1;
        exp_mem_req = 1'b1;
        exp_we      = !load;
        exp_addr    = ea[31:2];
        exp_mask    = m_mask(size, ea);
        exp_wdata   = m_wdata(size, sdata);
        for (int i = 0; i < wait_cyc; i++) begin
            if (i == flush_cyc) begin
                bus.flush = 1'b1;
                killed = load;
            end
            @(posedge CLK); #1;
            bus.flush = 1'b0;
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        @(posedge CLK); #1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom();
        exp_mem_req = 1'b0;
        if (load && !killed) begin
            exp_q.push_back({dest, m_load(size, sgn, ea, rdata)});
            exp_wb_valid = 1'b1;
            @(posedge CLK); #1;
            exp_wb_valid = 1'b0;
        end
        exp_busy = 1'b0;
    endtask

    initial begin
        #100000;
        checks++;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        RSTb = 1'b0;
        bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
        bus.req_base = '0; bus.req_offset = '0; bus.req_store_data = '0; bus.req_dest = '0;
        bus.flush = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        bus64.req_valid = 1'b0; bus64.req_load = 1'b0; bus64.req_size = 2'd0; bus64.req_signed = 1'b0;
        bus64.req_base = '0; bus64.req_offset = '0; bus64.req_store_data = '0; bus64.req_dest = '0;
        bus64.flush = 1'b0; bus64.mem_ack = 1'b0; bus64.mem_rdata = '0;
        #3;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_stall", bus.stall, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_wb_data", bus.wb_data, 0);
        @(posedge CLK); #1;
        RSTb = 1'b1;
        @(posedge CLK); #1;

        // Store byte: ea=0x1003.
        fork
            do_op(1'b0, 2'd0, 1'b0, 32'h1000, 24'h000003, 32'h000000A5, 4'd0, 2, 32'h0, -1);
            begin
                @(posedge CLK); #2;
                check("sb_addr", bus.mem_addr, 30'h400);
                check("sb_mask", bus.mem_mask, 4'b1000);
                check("sb_wdata", bus.mem_wdata, 32'hA5A5A5A5);
                check("sb_we", bus.mem_we, 1);
            end
        join

        // Load half signed at ea=0x2002.
        fork
            do_op(1'b1, 2'd1, 1'b1, 32'h2000, 24'h000002, 32'h0, 4'd5, 1, 32'h80017FFF, -1);
            begin
                @(posedge CLK); #2;
                check("lh_mask", bus.mem_mask, 4'b1100);
            end
        join
        check("lh_wb_data", bus.wb_data, 32'hFFFF8001);
        check("lh_wb_reg", bus.wb_reg, 4'd5);

        // Load word with negative offset, ack in the first mem_req cycle.
        fork
            do_op(1'b1, 2'd2, 1'b0, 32'h10, 24'hFFFFF0, 32'h0, 4'd9, 0, 32'h12345678, -1);
            begin
                @(posedge CLK); #2;
                check("lw_addr", bus.mem_addr, 30'h0);
            end
        join
        check("lw_wb_data", bus.wb_data, 32'h12345678);

        // Misaligned word and illegal dword.
        fork
            do_op(1'b1, 2'd2, 1'b0, 32'h1000, 24'h000002, 32'h0, 4'd1, 0, 32'h0, -1);
            begin
                @(posedge CLK); #2;
                check("mis_pulse", bus.misalign, 1);
                check("mis_ready", bus.req_ready, 1);
            end
        join
        do_op(1'b0, 2'd3, 1'b0, 32'h0, 24'h0, 32'h1, 4'd1, 0, 32'h0, -1);

        // Further patterns.
        do_op(1'b1, 2'd0, 1'b0, 32'h3001, 24'h0, 32'h0, 4'd2, 1, 32'h1122F344, -1);
        check("lbu_wb_data", bus.wb_data, 32'h000000F3);
        do_op(1'b1, 2'd0, 1'b1, 32'h3003, 24'h0, 32'h0, 4'd3, 0, 32'h80000000, -1);
        check("lb_wb_data", bus.wb_data, 32'hFFFFFF80);
        do_op(1'b0, 2'd1, 1'b0, 32'h0, 24'h000002, 32'h1234BEEF, 4'd0, 3, 32'h0, -1);
        do_op(1'b1, 2'd1, 1'b0, 32'h4000, 24'h0, 32'h0, 4'd7, 2, 32'h5555C001, -1);
        check("lhu_wb_data", bus.wb_data, 32'h0000C001);
        fork
            do_op(1'b0, 2'd2, 1'b0, 32'h0, 24'hFFFFFC, 32'hDEADBEEF, 4'd0, 1, 32'h0, -1);
            begin
                @(posedge CLK); #2;
                check("wrap_addr", bus.mem_addr, 30'h3FFFFFFF);
            end
        join

        // Flushed offer in IDLE is dropped.
        bus.req_valid = 1'b1; bus.flush = 1'b1; bus.req_load = 1'b1; bus.req_size = 2'd2;
        @(posedge CLK); #1;
        bus.req_valid = 1'b0; bus.flush = 1'b0;
        @(posedge CLK); #1;

        // Load flushed during ACCESS, store flushed during ACCESS.
        do_op(1'b1, 2'd2, 1'b0, 32'h100, 24'h0, 32'h0, 4'd4, 3, 32'hCAFEF00D, 1);
        check("killed_wb_hold", bus.wb_data, 32'h0000C001);
        do_op(1'b0, 2'd2, 1'b0, 32'h200, 24'h0, 32'h87654321, 4'd0, 2, 32'h0, 0);

        // Reset in the middle of an access.
        bus.req_valid = 1'b1; bus.req_load = 1'b1; bus.req_size = 2'd2;
        bus.req_base = 32'h300; bus.req_offset = '0;
        @(posedge CLK); #1;
        bus.req_valid = 1'b0;
        exp_busy = 1'b1; exp_mem_req = 1'b1; exp_we = 1'b0;
        exp_addr = 30'hC0; exp_mask = 4'hF; exp_wdata = bus.req_store_data;
        #2;
        RSTb = 1'b0;
        exp_busy = 1'b0; exp_mem_req = 1'b0;
        #1;
        check("arst_mem_req", bus.mem_req, 0);
        check("arst_stall", bus.stall, 0);
        check("arst_wb_valid", bus.wb_valid, 0);
        check("arst_req_ready", bus.req_ready, 1);
        check("arst_wb_data", bus.wb_data, 0);
        @(posedge CLK); @(posedge CLK); #1;
        RSTb = 1'b1;
        do_op(1'b1, 2'd0, 1'b1, 32'h501, 24'h0, 32'h0, 4'd6, 1, 32'h00007F00, -1);
        check("post_rst_wb_data", bus.wb_data, 32'h0000007F);

        // 64-bit instance: dword store at ea=0x8, then signed byte load at lane 5.
        bus64.req_valid = 1'b1; bus64.req_load = 1'b0; bus64.req_size = 2'd3;
        bus64.req_base = 64'h8; bus64.req_offset = '0;
        bus64.req_store_data = 64'h0123456789ABCDEF;
        @(posedge CLK); #1;
        bus64.req_valid = 1'b0;
        check("d64_mem_req", bus64.mem_req, 1);
        check("d64_mask", bus64.mem_mask, 8'hFF);
        check("d64_addr", bus64.mem_addr, 29'h1);
        check("d64_wdata", bus64.mem_wdata, 64'h0123456789ABCDEF);
        check("d64_we", bus64.mem_we, 1);
        bus64.mem_ack = 1'b1;
        @(posedge CLK); #1;
        bus64.mem_ack = 1'b0;
        check("d64_ready", bus64.req_ready, 1);
        bus64.req_valid = 1'b1; bus64.req_load = 1'b1; bus64.req_size = 2'd0;
        bus64.req_signed = 1'b1; bus64.req_base = 64'h5; bus64.req_dest = 4'd3;
        @(posedge CLK); #1;
        bus64.req_valid = 1'b0;
        check("b64_mask", bus64.mem_mask, 8'b0010_0000);
        bus64.mem_ack = 1'b1; bus64.mem_rdata = 64'h0000800000000000;
        @(posedge CLK); #1;
        bus64.mem_ack = 1'b0;
        check("b64_wb_valid", bus64.wb_valid, 1);
        check("b64_wb_data", bus64.wb_data, 64'hFFFFFFFFFFFFFF80);
        check("b64_wb_reg", bus64.wb_reg, 4'd3);
        @(posedge CLK); #1;

        check("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
